// File: rtl/cmd_cntrl_mq_if.sv
// Command/ID handshake and motion-status bundle between the line-follower
// command controller and its neighbours (UART receiver, ID receiver, motion).
interface cmd_cntrl_mq_if #(
  parameter int DEPTH  = 4,
  parameter int DEST_W = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              cmd_rdy;
  logic [7:0]        cmd;
  logic              clr_cmd_rdy;
  logic              ID_vld;
  logic [7:0]        ID;
  logic              clr_ID_vld;
  logic              OK2Move;
  logic              in_transit;
  logic              go;
  logic              buzz;
  logic              buzz_n;
  logic [DEST_W-1:0] dest;
  logic [CNT_W-1:0]  q_cnt;
  logic              q_ovf;
  logic              arrived;

  modport master (
    output cmd_rdy, cmd, ID_vld, ID, OK2Move,
    input  clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n,
           dest, q_cnt, q_ovf, arrived
  );

  modport slave (
    input  cmd_rdy, cmd, ID_vld, ID, OK2Move,
    output clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n,
           dest, q_cnt, q_ovf, arrived
  );
endinterface

// File: rtl/cmd_cntrl_mq.sv
// Route controller: queues destination IDs from go/append/stop commands,
// matches station barcodes against the current destination, drives motion and buzzer.
module cmd_cntrl_mq #(
  parameter int DEPTH    = 4,
  parameter int DEST_W   = 6,
  parameter int BUZZ_DIV = 12500
) (
  input logic          clk,
  input logic          rst,
  cmd_cntrl_mq_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BZ_W  = $clog2(BUZZ_DIV + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MOVING = 1'b1;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_GO     = 2'b01;
  localparam logic [1:0] OP_APPEND = 2'b10;

  logic [0:0]        state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              arrived_q, arrived_d;
  logic [BZ_W-1:0]   bz_cnt_q, bz_cnt_d;
  logic              buzz_q, buzz_d;
  logic [DEST_W-1:0] mem_q [DEPTH];

  logic       push;
  logic       start;
  logic       id_match;
  logic [1:0] op;

  assign op       = bus.cmd[7:6];
  assign id_match = ((bus.ID >> DEST_W) == 8'd0) && (bus.ID[DEST_W-1:0] == dest_q);

  // Commands always win the cycle; a pending ID waits until cmd_rdy drops.
  assign bus.clr_cmd_rdy = bus.cmd_rdy;
  assign bus.clr_ID_vld  = bus.ID_vld & ~bus.cmd_rdy;

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    dest_d    = dest_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    arrived_d = 1'b0;
    push      = 1'b0;
    start     = 1'b0;

    if (bus.cmd_rdy) begin
      case (op)
        OP_GO:     start = 1'b1;
        OP_APPEND: begin
          if (state_q == IDLE)              start = 1'b1;
          else if (cnt_q == CNT_W'(DEPTH))  ovf_d = 1'b1;
          else                              push  = 1'b1;
        end
        OP_STOP: begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = IDLE;
        end
        default: ;
      endcase
      if (start) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        dest_d   = bus.cmd[DEST_W-1:0];
        state_d  = MOVING;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end else if (bus.ID_vld && state_q == MOVING && id_match) begin
      arrived_d = 1'b1;
      if (cnt_q != '0) begin
        dest_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d    = cnt_q - CNT_W'(1);
      end else begin
        state_d  = IDLE;
      end
    end
  end

  // Buzzer runs only while routed but blocked; any other time it is silent and rearmed.
  always_comb begin
    bz_cnt_d = '0;
    buzz_d   = 1'b0;
    if (state_q == MOVING && !bus.OK2Move) begin
      if (bz_cnt_q == BZ_W'(BUZZ_DIV - 1)) begin
        bz_cnt_d = '0;
        buzz_d   = ~buzz_q;
      end else begin
        bz_cnt_d = bz_cnt_q + BZ_W'(1);
        buzz_d   = buzz_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      arrived_q <= 1'b0;
      bz_cnt_q  <= '0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      arrived_q <= arrived_d;
      bz_cnt_q  <= bz_cnt_d;
      buzz_q    <= buzz_d;
    end
  end

  // NOTE: queue storage is not reset; cnt/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.cmd[DEST_W-1:0];
  end

  assign bus.in_transit = (state_q == MOVING);
  assign bus.go         = (state_q == MOVING) & bus.OK2Move;
  assign bus.buzz       = buzz_q;
  assign bus.buzz_n     = ~buzz_q;
  assign bus.dest       = dest_q;
  assign bus.q_cnt      = cnt_q;
  assign bus.q_ovf      = ovf_q;
  assign bus.arrived    = arrived_q;
endmodule

// File: tb/tb_cmd_cntrl_mq.sv
// Directed bench for cmd_cntrl_mq: stimulus pushes expected arrival snapshots,
// a negedge monitor pops and compares them whenever arrived pulses.
module tb_cmd_cntrl_mq;
  localparam int DEPTH = 4;
  localparam int DEST_W = 6;

  typedef struct {
    logic [DEST_W-1:0] dest;
    logic              in_transit;
    logic [2:0]        q_cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_arr  = 0;
  exp_t exp_q[$];

  cmd_cntrl_mq_if #(.DEPTH(DEPTH), .DEST_W(DEST_W)) bus ();

  cmd_cntrl_mq #(.DEPTH(DEPTH), .DEST_W(DEST_W), .BUZZ_DIV(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_arrival(input logic [DEST_W-1:0] d, input logic t, input logic [2:0] q);
    exp_t e;
    e.dest = d;
    e.in_transit = t;
    e.q_cnt = q;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_rdy = 1'b1;
    bus.cmd = b;
    #1 check("clr_cmd_rdy", 32'(bus.clr_cmd_rdy), 32'd1);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
  endtask

  task automatic send_id(input logic [7:0] b);
    @(negedge clk);
    bus.ID_vld = 1'b1;
    bus.ID = b;
    #1 check("clr_ID_vld", 32'(bus.clr_ID_vld), 32'd1);
    @(negedge clk);
    bus.ID_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_transit"}, 32'(bus.in_transit), 32'd0);
    check({tag, ".go"},         32'(bus.go),         32'd0);
    check({tag, ".buzz"},       32'(bus.buzz),       32'd0);
    check({tag, ".buzz_n"},     32'(bus.buzz_n),     32'd1);
    check({tag, ".dest"},       32'(bus.dest),       32'd0);
    check({tag, ".q_cnt"},      32'(bus.q_cnt),      32'd0);
    check({tag, ".q_ovf"},      32'(bus.q_ovf),      32'd0);
    check({tag, ".arrived"},    32'(bus.arrived),    32'd0);
  endtask

  // Monitor: every arrived pulse must match the oldest expected snapshot.
  always @(negedge clk) begin
    if (!rst && bus.arrived === 1'b1) begin
      n_arr++;
      if (exp_q.size() == 0) begin
        check("unexpected_arrival.dest", 32'(bus.dest), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("arr.dest",       32'(bus.dest),       32'(e.dest));
        check("arr.in_transit", 32'(bus.in_transit), 32'(e.in_transit));
        check("arr.q_cnt",      32'(bus.q_cnt),      32'(e.q_cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_rdy = 1'b0;
    bus.cmd = 8'h00;
    bus.ID_vld = 1'b0;
    bus.ID = 8'h00;
    bus.OK2Move = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single destination: wrong and out-of-range IDs are ignored, exact match arrives.
    send_cmd(8'h50);
    check("t1.in_transit", 32'(bus.in_transit), 32'd1);
    check("t1.go",         32'(bus.go),         32'd1);
    check("t1.dest",       32'(bus.dest),       32'h10);
    send_id(8'h11);
    send_id(8'h50);
    check("t1.still_moving", 32'(bus.in_transit), 32'd1);
    expect_arrival(6'h10, 1'b0, 3'd0);
    send_id(8'h10);
    check("t1.idle",    32'(bus.in_transit), 32'd0);
    check("t1.go_low",  32'(bus.go),         32'd0);

    // Three-stop route with no idle gap between legs.
    send_cmd(8'h45);
    send_cmd(8'h87);
    send_cmd(8'h89);
    check("t2.q_cnt", 32'(bus.q_cnt), 32'd2);
    expect_arrival(6'h07, 1'b1, 3'd1);
    send_id(8'h05);
    expect_arrival(6'h09, 1'b1, 3'd0);
    send_id(8'h07);
    expect_arrival(6'h09, 1'b0, 3'd0);
    send_id(8'h09);

    // Overflow: fifth append dropped and never reached; STOP clears the sticky flag.
    send_cmd(8'h41);
    send_cmd(8'h82);
    send_cmd(8'h83);
    send_cmd(8'h84);
    send_cmd(8'h85);
    check("t3.q_ovf_pre", 32'(bus.q_ovf), 32'd0);
    send_cmd(8'h86);
    check("t3.q_cnt_full", 32'(bus.q_cnt), 32'd4);
    check("t3.q_ovf",      32'(bus.q_ovf), 32'd1);
    expect_arrival(6'h02, 1'b1, 3'd3);
    send_id(8'h01);
    expect_arrival(6'h03, 1'b1, 3'd2);
    send_id(8'h02);
    expect_arrival(6'h04, 1'b1, 3'd1);
    send_id(8'h03);
    expect_arrival(6'h05, 1'b1, 3'd0);
    send_id(8'h04);
    check("t3.q_ovf_sticky", 32'(bus.q_ovf), 32'd1);
    send_cmd(8'h00);
    check("t3.stop_q_cnt", 32'(bus.q_cnt),      32'd0);
    check("t3.stop_q_ovf", 32'(bus.q_ovf),      32'd0);
    check("t3.stop_idle",  32'(bus.in_transit), 32'd0);
    check("t3.stop_dest",  32'(bus.dest),       32'h05);
    send_id(8'h05);

    // Command and matching ID in the same cycle: append first, then advance.
    send_cmd(8'h4A);
    @(negedge clk);
    bus.cmd_rdy = 1'b1;
    bus.cmd = 8'h8B;
    bus.ID_vld = 1'b1;
    bus.ID = 8'h0A;
    #1;
    check("t4.clr_cmd_rdy", 32'(bus.clr_cmd_rdy), 32'd1);
    check("t4.clr_ID_vld",  32'(bus.clr_ID_vld),  32'd0);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    check("t4.q_cnt_grew", 32'(bus.q_cnt), 32'd1);
    #1 check("t4.clr_ID_late", 32'(bus.clr_ID_vld), 32'd1);
    expect_arrival(6'h0B, 1'b1, 3'd0);
    @(negedge clk);
    bus.ID_vld = 1'b0;
    send_cmd(8'h8C);
    check("t4.q_cnt_app", 32'(bus.q_cnt), 32'd1);
    send_cmd(8'h00);
    check("t4.stop_q_cnt", 32'(bus.q_cnt),      32'd0);
    check("t4.stop_idle",  32'(bus.in_transit), 32'd0);
    check("t4.stop_dest",  32'(bus.dest),       32'h0B);

    // Buzzer while blocked: toggles every 4 clocks, rearms after clearing.
    send_cmd(8'h41);
    bus.OK2Move = 1'b0;
    #1 check("t5.go_blocked", 32'(bus.go), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("t5.buzz",   32'(bus.buzz),   32'((k / 4) % 2));
      check("t5.buzz_n", 32'(bus.buzz_n), 32'(1 - (k / 4) % 2));
    end
    bus.OK2Move = 1'b1;
    #1 check("t5.go_clear", 32'(bus.go), 32'd1);
    @(negedge clk);
    check("t5.buzz_off",   32'(bus.buzz),   32'd0);
    check("t5.buzz_n_off", 32'(bus.buzz_n), 32'd1);
    bus.OK2Move = 1'b0;
    repeat (3) @(negedge clk);
    check("t5.rearm_quiet", 32'(bus.buzz), 32'd0);
    @(negedge clk);
    check("t5.rearm_toggle", 32'(bus.buzz), 32'd1);
    bus.OK2Move = 1'b1;
    send_cmd(8'h00);

    // Asynchronous reset mid-route discards the queue and destination.
    send_cmd(8'h41);
    send_cmd(8'h82);
    send_cmd(8'h83);
    send_cmd(8'h84);
    check("t6.q_cnt", 32'(bus.q_cnt), 32'd3);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    send_id(8'h01);
    check("t6.no_arrival", 32'(bus.arrived),    32'd0);
    check("t6.idle",       32'(bus.in_transit), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained",  32'(exp_q.size()), 32'd0);
    check("arrivals",    32'(n_arr),        32'd9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_cntrl_mq.md
Name: cmd_cntrl_mq

Overview:
- Next-generation command/ID controller for the line-follower digital core, replacing the single-destination command block.
- Accepts go/append/stop commands from the UART command receiver and keeps a parametrised FIFO of pending destination station IDs.
- Matches barcode IDs from the ID receiver against the current destination and advances through the route.
- Drives go/in_transit to the motion controller and the obstacle buzzer.

Parameters:
- DEPTH, 4, number of queued destinations behind the current one (power of 2, ≥2)
- DEST_W, 6, destination/station ID width (1..6)
- BUZZ_DIV, 12500, clocks per buzzer half-period

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_rdy  in  1  command byte valid
- cmd  in  8  command byte: [7:6] opcode, [5:0] destination
- clr_cmd_rdy  out  1  command consumed (combinational)
- ID_vld  in  1  station ID valid
- ID  in  8  station ID byte
- clr_ID_vld  out  1  ID consumed (combinational)
- OK2Move  in  1  proximity sensor clear
- in_transit  out  1  route active
- go  out  1  motion enable = in_transit & OK2Move
- buzz  out  1  buzzer drive
- buzz_n  out  1  complement of buzz
- dest  out  DEST_W  current destination
- q_cnt  out  $clog2(DEPTH+1)  queued entries, excluding dest
- q_ovf  out  1  sticky: append dropped because queue was full
- arrived  out  1  one-cycle pulse on destination match

Behaviour:
- Reset values: in_transit=0, go=0, buzz=0, buzz_n=1, dest=0, q_cnt=0, q_ovf=0, arrived=0. Queue pointers cleared; FSM to IDLE; buzzer counter cleared.
- FSM states: IDLE, MOVING. in_transit=1 iff state==MOVING, registered.
- Command consume:
  - clr_cmd_rdy=cmd_rdy, same cycle.
  - The command takes effect on that edge, so in_transit/dest change one clock after cmd_rdy is first seen.
- Opcodes:
  - 01 GO: flush queue, dest<=cmd[DEST_W-1:0], q_ovf<=0, go to MOVING. Accepted in either state.
  - 10 APPEND in IDLE: behaves exactly as GO.
  - 10 APPEND in MOVING: if q_cnt<DEPTH, push cmd[DEST_W-1:0]. If q_cnt==DEPTH, drop the command and set q_ovf.
  - 00 STOP: flush queue, q_ovf<=0, go to IDLE. dest holds its value.
  - 11: consumed, no effect.
- ID consume:
  - clr_ID_vld=ID_vld, except in a cycle where cmd_rdy is also high. The command wins; the ID stays pending and is handled on a later cycle.
  - IDs in IDLE are consumed and discarded.
- ID match in MOVING requires ID[7:DEST_W]==0 and ID[DEST_W-1:0]==dest. On match, arrived pulses next cycle.
  - q_cnt>0: dest<=FIFO head, pop, stay MOVING. No idle gap: in_transit stays 1.
  - q_cnt==0: go to IDLE.
  - Non-matching or out-of-range IDs: consumed, ignored.
- FIFO:
  - Circular buffer with wrap-around pointers; q_cnt ranges 0..DEPTH.
  - A push and a pop cannot occur in the same cycle, because command priority serialises them.
- Buzzer:
  - When in_transit & ~OK2Move, a counter runs 0..BUZZ_DIV-1 and toggles buzz at terminal count.
  - Otherwise the counter is cleared and buzz=0.
  - buzz_n=~buzz always.
- go is combinational from the registered in_transit and OK2Move; it drops within the same cycle OK2Move falls.
- Reset asserted mid-route forces all reset values immediately, asynchronously, and discards the queue.

Test Plan:
- Reset, then GO 0x50 (dest 0x10) -> clr_cmd_rdy high the same cycle; next cycle in_transit=1, go=1, dest=0x10. ID 0x11 -> ignored. ID 0x10 -> arrived pulse, in_transit=0 and go=0 one cycle later.
- GO 0x45, APPEND 0x87, APPEND 0x89 -> q_cnt=2.
  - ID 0x05 -> dest=0x07, q_cnt=1, in_transit stays 1.
  - ID 0x07 -> dest=0x09.
  - ID 0x09 -> IDLE.
  - Three arrived pulses in total.
- GO, then DEPTH+1 APPENDs (DEPTH=4) -> q_cnt=4, q_ovf=1, fifth destination never reached. A following STOP (0x00) -> q_cnt=0, q_ovf=0, in_transit=0.
- cmd_rdy and a matching ID_vld asserted in the same cycle -> clr_cmd_rdy=1, clr_ID_vld=0 that cycle; the ID is consumed the next cycle.
  - If the command was an APPEND, the queue grows first and then advances.
- MOVING with OK2Move=0 (BUZZ_DIV=4 in bench) -> go=0 and buzz toggles every 4 clocks with buzz_n complementary. OK2Move=1 -> buzz=0, go=1.
- Assert rst mid-route with q_cnt=3 -> all outputs immediately at reset values. After release, ID matching the old dest -> no arrived pulse.
